// File: rtl/add512_seq_if.sv
// Operand/result handshake bundle for add512_seq.
// Carries in_acc only when ADD512_ACCUM_EN is defined.
interface add512_seq_if #(
  parameter int W = 512
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
`ifdef ADD512_ACCUM_EN
  logic         in_acc;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_ci,
`ifdef ADD512_ACCUM_EN
    output in_acc,
`endif
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_co, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci,
`ifdef ADD512_ACCUM_EN
    input  in_acc,
`endif
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_co, busy
  );
endinterface

// File: rtl/add512_seq.sv
// Sequential W-bit adder: one shared SLICE-bit lookahead adder per cycle.
// ADD512_ACCUM_EN adds in_acc: B operand taken from the last out_sum.
module add512_seq #(
  parameter int W     = 512,
  parameter int SLICE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  add512_seq_if.slave bus
);
  localparam int NS = W / SLICE;
  localparam int CW = $clog2(NS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   sum_q;
  logic [CW-1:0]  cnt;
  logic           cy;
  logic           co_q;
  logic           vld_q;
  logic           rdy_q;
  logic           busy_q;

  logic [W-1:0]     b_sel;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] gg;
  logic [SLICE-1:0] pp;
  logic [SLICE-1:0] gp;
  logic [SLICE-1:0] pr;
  logic [SLICE-1:0] cvec;
  logic [SLICE-1:0] s;
  logic             sco;

`ifdef ADD512_ACCUM_EN
  assign b_sel = bus.in_acc ? sum_q : bus.in_b;
`else
  assign b_sel = bus.in_b;
`endif

  assign a_sl = a_q[int'(cnt)*SLICE +: SLICE];
  assign b_sl = b_q[int'(cnt)*SLICE +: SLICE];

  // Parallel-prefix carries; carry-in folded into bit 0 generate.
  always_comb begin
    gg = a_sl & b_sl;
    pp = a_sl ^ b_sl;
    gp = gg;
    pr = pp;
    gp[0] = gg[0] | (pp[0] & cy);
    for (int d = 1; d < SLICE; d = d * 2) begin
      for (int i = SLICE - 1; i >= d; i--) begin
        gp[i] = gp[i] | (pr[i] & gp[i-d]);
        pr[i] = pr[i] & pr[i-d];
      end
    end
    cvec = {gp[SLICE-2:0], cy};
    s    = pp ^ cvec;
    sco  = gp[SLICE-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      co_q   <= 1'b0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && rdy_q) begin
            a_q    <= bus.in_a;
            b_q    <= b_sel;
            cy     <= bus.in_ci;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_q[int'(cnt)*SLICE +: SLICE] <= s;
          cy <= sco;
          if (cnt == LAST) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Publish once on entry so out_sum only moves with out_valid.
          if (!vld_q) begin
            sum_q <= res_q;
            co_q  <= cy;
            vld_q <= 1'b1;
          end else if (bus.out_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_co    = co_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_add512_seq.sv
// Scoreboard bench for add512_seq.
// Define ADD512_ACCUM_EN to also exercise in_acc.
module tb_add512_seq;
  localparam int W = 512;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t q[$];
  logic [W-1:0] last_sum;

  add512_seq_if #(.W(W)) bus();

  add512_seq #(.W(W), .SLICE(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W:0] obs, logic [W:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic acc,
                        input int hold, input bit scribble);
    logic [W:0]   full;
    logic [W-1:0] bv;
    exp_t         e;
    int           n;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ci    = ci;
`ifdef ADD512_ACCUM_EN
    bus.in_acc   = acc;
`endif
    bus.in_valid = 1'b1;
    chk("in_ready_idle", W'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bv   = acc ? last_sum : b;
    full = {1'b0, a} + {1'b0, bv} + (W+1)'(ci);
    q.push_back('{s: full[W-1:0], c: full[W]});
    last_sum = full[W-1:0];
    chk("busy_run", W'(bus.busy), 1);
    chk("in_ready_run", W'(bus.in_ready), 0);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      if (scribble) begin
        bus.in_a     = rnd();
        bus.in_b     = rnd();
        bus.in_ci    = ~bus.in_ci;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      n = k;
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    chk("latency", (W+1)'(n), 9);
    chk("out_valid", W'(bus.out_valid), 1);
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      chk("sum", {1'b0, bus.out_sum}, {1'b0, e.s});
      chk("co", W'(bus.out_co), W'(e.c));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", W'(bus.out_valid), 1);
        chk("hold_sum", {1'b0, bus.out_sum}, {1'b0, e.s});
        chk("hold_co", W'(bus.out_co), W'(e.c));
        chk("hold_in_ready", W'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("idle_in_ready", W'(bus.in_ready), 1);
      chk("idle_valid", W'(bus.out_valid), 0);
      chk("idle_busy", W'(bus.busy), 0);
      chk("keep_sum", {1'b0, bus.out_sum}, {1'b0, e.s});
    end
  endtask

  initial begin
    logic [W-1:0] x;
    logic         ok;
    total = 0;
    bad   = 0;
    last_sum      = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_ci     = 1'b0;
`ifdef ADD512_ACCUM_EN
    bus.in_acc    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(bus.in_ready), 1);
    chk("rst_valid", W'(bus.out_valid), 0);
    chk("rst_busy", W'(bus.busy), 0);
    chk("rst_sum", {1'b0, bus.out_sum}, 0);
    chk("rst_co", W'(bus.out_co), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(W'(1), W'(1), 1'b0, 1'b0, 0, 1'b0);
    run_op('1, '0, 1'b1, 1'b0, 0, 1'b0);
    x = '0;
    x[63:0] = '1;
    run_op(x, W'(1), 1'b0, 1'b0, 0, 1'b0);
    run_op(rnd(), rnd(), 1'b1, 1'b0, 5, 1'b1);
    for (int r = 0; r < 3; r++)
      run_op(rnd(), rnd(), 1'(r), 1'b0, r, 1'b0);
    run_op('1, '1, 1'b1, 1'b0, 0, 1'b0);

`ifdef ADD512_ACCUM_EN
    run_op(W'(3), W'(4), 1'b0, 1'b0, 0, 1'b0);
    run_op(W'(5), rnd(), 1'b0, 1'b1, 0, 1'b0);
    chk("acc_sum", {1'b0, bus.out_sum}, 12);
`endif

    // Reset while slice 4 is being computed.
    @(negedge clk);
    bus.in_a     = rnd();
    bus.in_b     = rnd();
    bus.in_ci    = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_run_busy", W'(bus.busy), 1);
    chk("mid_run_sum", {1'b0, bus.out_sum}, {1'b0, last_sum});
    rst_n = 1'b0;
    #1;
    chk("abort_valid", W'(bus.out_valid), 0);
    chk("abort_sum", {1'b0, bus.out_sum}, 0);
    chk("abort_busy", W'(bus.busy), 0);
    chk("abort_in_ready", W'(bus.in_ready), 1);
    last_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", W'(bus.in_ready), 1);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) ok = 1'b0;
    end
    chk("no_partial", W'(ok), 1);
    run_op(rnd(), rnd(), 1'b1, 1'b0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add512_seq.md
ADD512_SEQ -- requirements
Module: add512_seq

Interface
REQ-001 SHALL have parameter W, default 512: total operand width.
REQ-002 SHALL have parameter SLICE, default 64: adder slice width; W SHALL be an integer multiple of SLICE, and NS = W/SLICE.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port in_a  input  W  addend A.
REQ-008 SHALL have port in_b  input  W  addend B.
REQ-009 SHALL have port in_ci  input  1  carry-in to bit 0.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_sum  output  W  A+B+ci modulo 2^W.
REQ-013 SHALL have port out_co  output  1  carry out of bit W-1.
REQ-014 SHALL have port busy  output  1  high in RUN state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; acceptance occurs on in_valid & in_ready at a rising edge.
REQ-017 SHALL on acceptance capture in_a, in_b into internal registers, load the carry register with in_ci, clear the slice counter, and enter RUN.
REQ-018 SHALL in RUN process one slice per cycle, k = 0..NS-1, LSB slice first: sum slice k = A[k] + B[k] + carry; write it to result slice k; register the slice carry-out as the next carry.
REQ-019 SHALL use one SLICE-bit combinational adder (carry-lookahead) shared across all slices; no W-bit adder is permitted.
REQ-020 SHALL after slice NS-1 store its carry-out as out_co and enter DONE; out_valid SHALL rise exactly NS+1 cycles after the acceptance edge (9 for defaults).
REQ-021 SHALL assert out_valid only in DONE, and hold out_sum and out_co stable while out_valid is high and out_ready is low.
REQ-022 SHALL on out_valid & out_ready return to IDLE; in_ready SHALL be high the following cycle; out_sum/out_co SHALL retain their last value until the next DONE.
REQ-023 SHALL ignore in_a, in_b, in_ci and in_valid changes while not in IDLE.
REQ-024 SHALL take the slice counter exactly from 0 to NS-1 with no wrap past NS-1; the counter SHALL be ceil(log2(NS))+1 bits wide.

Reset
REQ-025 SHALL on rst_n low immediately force state IDLE, counter 0, carry 0, out_sum 0, out_co 0, out_valid 0, busy 0; in_ready SHALL be 1 while rst_n is low and after reset.
REQ-026 SHALL abort any in-progress addition when reset occurs mid-RUN or in DONE; no partial result SHALL be presented after reset release.

Configuration
REQ-027 SHALL support macro ADD512_ACCUM_EN: when defined, add port in_acc (input, 1); on acceptance with in_acc=1, the B operand SHALL be the current out_sum register instead of in_b.
REQ-028 SHALL behave as if in_acc=0 when ADD512_ACCUM_EN is undefined; in that case the in_acc port SHALL be absent.

Verification
REQ-029 SHALL verify A=1, B=1, ci=0 -> out_sum=2, out_co=0, out_valid high exactly 9 cycles after acceptance.
REQ-030 SHALL verify A=all ones, B=0, ci=1 -> out_sum=0, out_co=1 (carry ripples through all 8 slices).
REQ-031 SHALL verify A=2^64-1, B=1, ci=0 -> out_sum=2^64 (bit 64 set, all other bits 0), out_co=0.
REQ-032 SHALL verify out_ready held low 5 cycles in DONE -> out_valid, out_sum and out_co stable and in_ready 0; out_ready=1 -> IDLE next cycle with in_ready=1.
REQ-033 SHALL verify rst_n pulsed low during slice 4 -> out_valid=0, out_sum=0, busy=0 at once, and in_ready=1 after release.
REQ-034 SHALL verify, with ADD512_ACCUM_EN defined, a first add A=3, B=4 -> 7, followed by A=5 with in_acc=1 -> out_sum=12.
